priority_encoder_4_2_handshake: RTL and testbench

- Sequential 4-to-2 priority encoder; the return path for the 2-4 decoder's one-hot lines.
- Captures events on four request lines into a pending register and presents them one at a time as a 2-bit index with a valid/ready handshake.
- Sits between one-hot status/event sources and a consumer that needs the encoded index, such as an interrupt or arbitration front-end.

---
 rtl/encoder_pkg.sv | 38 +++
 rtl/priority_select_4_2.sv | 37 +++
 rtl/priority_encoder_4_2_handshake.sv | 149 ++++++++++++++
 tb/tb_priority_encoder_4_2_handshake.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// -----------------------------------------------------------------------------
// encoder_pkg
// Shared definitions for the 4-to-2 handshake priority encoder.
//   NUM_LINES - number of request lines (4)
//   IDX_W     - width of the encoded index (2)
//   state_e   - handshake FSM state encoding (IDLE / PRESENT)
//   onehot()  - index -> one-hot mask over NUM_LINES
//   popcount()- number of set bits in a NUM_LINES-wide vector
// -----------------------------------------------------------------------------
package encoder_pkg;

  localparam int NUM_LINES = 4;
  localparam int IDX_W     = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // One-hot mask for a line index; used to clear the pending bit being loaded.
  function automatic logic [NUM_LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_LINES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Count of set bits; IDX_W+1 bits holds the full range 0..NUM_LINES.
  function automatic logic [IDX_W:0] popcount(input logic [NUM_LINES-1:0] v);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/priority_select_4_2.sv
// -----------------------------------------------------------------------------
// priority_select_4_2
// Combinational priority select over the registered pending vector.
//   HIGH_FIRST (param) - 1: index 3 wins, 0: index 0 wins
//   pending  in  [3:0] - pending request bits
//   sel      out [1:0] - index of the winning request (0 when none pending)
//   any      out       - at least one request is pending
// -----------------------------------------------------------------------------
module priority_select_4_2
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [NUM_LINES-1:0] pending,
  output logic [IDX_W-1:0]     sel,
  output logic                 any
);

  // NOTE: every output gets a default before the loops so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel = '0;
    any = |pending;
    // The last matching line scanned overwrites earlier ones, so the scan
    // direction sets the priority: scan upward when the highest index wins.
    if (HIGH_FIRST) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (pending[i]) sel = IDX_W'(i);
      end
    end else begin
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
        if (pending[i]) sel = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_encoder_4_2_handshake.sv
// -----------------------------------------------------------------------------
// priority_encoder_4_2_handshake
// Captures events on four request lines into a pending register and presents
// them one at a time as a 2-bit index with a valid/ready handshake.
//   HIGH_FIRST (param)  - 1: index 3 highest priority, 0: index 0 highest
//   EDGE_MODE  (param)  - 1: rising edge sets pending, 0: level sets pending
//   Clock_In            - single clock, rising edge
//   Reset_In            - synchronous active-high reset
//   Data_[0..3]_In      - request lines
//   Ready_In            - consumer accepts the presented index
//   Clear_Overflow_In   - clears the sticky overflow flag
//   Valid_Out           - Encoded_Value_Out is valid
//   Encoded_Value_Out   - index of the presented request
//   Multiple_Out        - another request was pending when this index loaded
//   Overflow_Out        - sticky: an edge arrived on an already-pending line
//   Pending_Out         - pending register (debug view)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module priority_encoder_4_2_handshake
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1,
  parameter bit EDGE_MODE  = 1'b1
) (
  input  logic             Clock_In,
  input  logic             Reset_In,
  input  logic             Data_0_In,
  input  logic             Data_1_In,
  input  logic             Data_2_In,
  input  logic             Data_3_In,
  input  logic             Ready_In,
  input  logic             Clear_Overflow_In,
  output logic             Valid_Out,
  output logic [IDX_W-1:0] Encoded_Value_Out,
  output logic             Multiple_Out,
  output logic             Overflow_Out,
  output logic [3:0]       Pending_Out
);

  state_e                 state_q, state_d;
  logic [NUM_LINES-1:0]   pending_q, pending_d;
  logic [NUM_LINES-1:0]   prev_q, prev_d;
  logic                   valid_q, valid_d;
  logic [IDX_W-1:0]       enc_q, enc_d;
  logic                   mult_q, mult_d;
  logic                   ovf_q, ovf_d;

  logic [NUM_LINES-1:0]   data_in;
  logic [NUM_LINES-1:0]   ev;
  logic [NUM_LINES-1:0]   clr;
  logic                   load;
  logic                   ovf_set;
  logic [IDX_W-1:0]       sel;
  logic                   any;

  assign data_in = {Data_3_In, Data_2_In, Data_1_In, Data_0_In};

  // Selection sees only the registered pending value, so an event arriving
  // this cycle cannot be presented before it has been captured.
  priority_select_4_2 #(
    .HIGH_FIRST (HIGH_FIRST)
  ) u_select (
    .pending (pending_q),
    .sel     (sel),
    .any     (any)
  );

  // Event detect. prev resets to 0, so a line already high when reset is
  // released yields exactly one event.
  always_comb begin
    prev_d = data_in;
    ev     = EDGE_MODE ? (data_in & ~prev_q) : data_in;
  end

  // Handshake FSM next-state and output staging.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    enc_d   = enc_q;
    mult_d  = mult_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (any) load = 1'b1;
      end
      PRESENT: begin
        if (Ready_In) begin
          if (any) begin
            // Reload in the accept cycle: back-to-back with no bubble.
            load = 1'b1;
          end else begin
            // Index is left holding its last value.
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    clr = '0;
    if (load) begin
      enc_d   = sel;
      mult_d  = (popcount(pending_q) > (IDX_W + 1)'(1));
      valid_d = 1'b1;
      state_d = PRESENT;
      clr     = onehot(sel);
    end
  end

  // Pending and overflow update. A new event on the bit being cleared keeps
  // it set (set wins), and that case is not an overflow since the old request
  // is leaving the register in the same cycle.
  always_comb begin
    pending_d = (pending_q & ~clr) | ev;
    ovf_set   = EDGE_MODE && (|(ev & pending_q & ~clr));
    ovf_d     = ovf_set | (ovf_q & ~Clear_Overflow_In);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q   <= IDLE;
      pending_q <= '0;
      prev_q    <= '0;
      valid_q   <= 1'b0;
      enc_q     <= '0;
      mult_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      prev_q    <= prev_d;
      valid_q   <= valid_d;
      enc_q     <= enc_d;
      mult_q    <= mult_d;
      ovf_q     <= ovf_d;
    end
  end

  assign Valid_Out         = valid_q;
  assign Encoded_Value_Out = enc_q;
  assign Multiple_Out      = mult_q;
  assign Overflow_Out      = ovf_q;
  assign Pending_Out       = pending_q;

endmodule

// File: tb/tb_priority_encoder_4_2_handshake.sv
// -----------------------------------------------------------------------------
// tb_priority_encoder_4_2_handshake
// Drives two encoder instances (HIGH_FIRST=1 and HIGH_FIRST=0) with the same
// request stimulus. Expected (index, multiple) pairs are queued when requests
// are driven and popped by a monitor whenever an index is accepted.
// -----------------------------------------------------------------------------
module tb_priority_encoder_4_2_handshake;

  typedef struct {
    logic [1:0] idx;
    logic       mult;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       rdy;
  logic       clr_ovf;

  logic       valid_hf, mult_hf, ovf_hf;
  logic [1:0] enc_hf;
  logic [3:0] pend_hf;
  logic       valid_lf, mult_lf, ovf_lf;
  logic [1:0] enc_lf;
  logic [3:0] pend_lf;

  exp_t q_hf[$];
  exp_t q_lf[$];
  exp_t e_hf, e_lf;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  priority_encoder_4_2_handshake #(.HIGH_FIRST(1'b1), .EDGE_MODE(1'b1)) dut_hf (
    .Clock_In          (clk),
    .Reset_In          (rst),
    .Data_0_In         (data[0]),
    .Data_1_In         (data[1]),
    .Data_2_In         (data[2]),
    .Data_3_In         (data[3]),
    .Ready_In          (rdy),
    .Clear_Overflow_In (clr_ovf),
    .Valid_Out         (valid_hf),
    .Encoded_Value_Out (enc_hf),
    .Multiple_Out      (mult_hf),
    .Overflow_Out      (ovf_hf),
    .Pending_Out       (pend_hf)
  );

  priority_encoder_4_2_handshake #(.HIGH_FIRST(1'b0), .EDGE_MODE(1'b1)) dut_lf (
    .Clock_In          (clk),
    .Reset_In          (rst),
    .Data_0_In         (data[0]),
    .Data_1_In         (data[1]),
    .Data_2_In         (data[2]),
    .Data_3_In         (data[3]),
    .Ready_In          (rdy),
    .Clear_Overflow_In (clr_ovf),
    .Valid_Out         (valid_lf),
    .Encoded_Value_Out (enc_lf),
    .Multiple_Out      (mult_lf),
    .Overflow_Out      (ovf_lf),
    .Pending_Out       (pend_lf)
  );

  // Scoreboard monitor: inputs change just after the rising edge, so at the
  // falling edge Valid & Ready show exactly what the next rising edge accepts.
  always @(negedge clk) begin
    if (rst === 1'b0 && rdy === 1'b1) begin
      if (valid_hf === 1'b1) begin
        tests_run++;
        if (q_hf.size() == 0) begin
          failures++;
          $display("FAIL sb_hf_unexpected: got idx %0d mult %0d, expected no transfer", enc_hf, mult_hf);
        end else begin
          e_hf = q_hf.pop_front();
          if ({enc_hf, mult_hf} !== {e_hf.idx, e_hf.mult}) begin
            failures++;
            $display("FAIL sb_hf: got idx %0d mult %0d, expected idx %0d mult %0d",
                     enc_hf, mult_hf, e_hf.idx, e_hf.mult);
          end
        end
      end
      if (valid_lf === 1'b1) begin
        tests_run++;
        if (q_lf.size() == 0) begin
          failures++;
          $display("FAIL sb_lf_unexpected: got idx %0d mult %0d, expected no transfer", enc_lf, mult_lf);
        end else begin
          e_lf = q_lf.pop_front();
          if ({enc_lf, mult_lf} !== {e_lf.idx, e_lf.mult}) begin
            failures++;
            $display("FAIL sb_lf: got idx %0d mult %0d, expected idx %0d mult %0d",
                     enc_lf, mult_lf, e_lf.idx, e_lf.mult);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [1:0] idx, input logic mult);
    q_hf.push_back('{idx: idx, mult: mult});
    q_lf.push_back('{idx: idx, mult: mult});
  endtask

  // Accept everything outstanding within a cycle budget.
  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    rdy  = 1'b1;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (q_hf.size() == 0 && q_lf.size() == 0 && valid_hf === 1'b0 && valid_lf === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!done) begin
      failures++;
      $display("FAIL %s_drain: left hf=%0d lf=%0d valid hf=%b lf=%b, expected all accepted",
               name, q_hf.size(), q_lf.size(), valid_hf, valid_lf);
    end
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; data = '0; rdy = 1'b0; clr_ovf = 1'b0;
    tick();
    tick();
    tests_run++;
    if ({valid_hf, enc_hf, mult_hf, ovf_hf, pend_hf} !== 9'd0) begin
      failures++;
      $display("FAIL reset_hf: got v%b e%0d m%b o%b p%b, expected all 0",
               valid_hf, enc_hf, mult_hf, ovf_hf, pend_hf);
    end
    tests_run++;
    if ({valid_lf, enc_lf, mult_lf, ovf_lf, pend_lf} !== 9'd0) begin
      failures++;
      $display("FAIL reset_lf: got v%b e%0d m%b o%b p%b, expected all 0",
               valid_lf, enc_lf, mult_lf, ovf_lf, pend_lf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    data = 4'b0100;
    tick();
    data = '0;
    push_both(2'd2, 1'b0);
    tick();
    tests_run++;
    if ({valid_hf, enc_hf, mult_hf} !== {1'b1, 2'd2, 1'b0}) begin
      failures++;
      $display("FAIL single_latency: got v%b e%0d m%b, expected v1 e2 m0", valid_hf, enc_hf, mult_hf);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    tests_run++;
    if ({valid_hf, pend_hf, valid_lf, pend_lf} !== 10'd0) begin
      failures++;
      $display("FAIL single_done: got v%b p%b / v%b p%b, expected v0 p0000",
               valid_hf, pend_hf, valid_lf, pend_lf);
    end
    tests_run++;
    if (q_hf.size() != 0 || q_lf.size() != 0) begin
      failures++;
      $display("FAIL single_sb: got %0d/%0d outstanding, expected 0", q_hf.size(), q_lf.size());
    end
  endtask

  task automatic test_back_to_back();
    rdy  = 1'b1;
    data = 4'b1011;
    tick();
    data = '0;
    q_hf.push_back('{idx: 2'd3, mult: 1'b1});
    q_hf.push_back('{idx: 2'd1, mult: 1'b1});
    q_hf.push_back('{idx: 2'd0, mult: 1'b0});
    q_lf.push_back('{idx: 2'd0, mult: 1'b1});
    q_lf.push_back('{idx: 2'd1, mult: 1'b1});
    q_lf.push_back('{idx: 2'd3, mult: 1'b0});
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({valid_hf, valid_lf} !== 2'b11) begin
        failures++;
        $display("FAIL b2b_valid_%0d: got hf %b lf %b, expected 1 1", i, valid_hf, valid_lf);
      end
    end
    tick();
    tests_run++;
    if ({valid_hf, valid_lf} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_drop: got hf %b lf %b, expected 0 0", valid_hf, valid_lf);
    end
    tests_run++;
    if (q_hf.size() != 0 || q_lf.size() != 0) begin
      failures++;
      $display("FAIL b2b_sb: got %0d/%0d outstanding, expected 0", q_hf.size(), q_lf.size());
    end
    rdy = 1'b0;
  endtask

  task automatic test_stall();
    rdy  = 1'b0;
    data = 4'b0001;
    tick();
    data = '0;
    push_both(2'd0, 1'b0);
    tick();
    for (int s = 0; s < 5; s++) begin
      if (s == 1) data[3] = 1'b1;
      if (s == 2) data[3] = 1'b0;
      tick();
      tests_run++;
      if ({valid_hf, enc_hf, valid_lf, enc_lf} !== {1'b1, 2'd0, 1'b1, 2'd0}) begin
        failures++;
        $display("FAIL stall_hold_%0d: got v%b e%0d / v%b e%0d, expected v1 e0",
                 s, valid_hf, enc_hf, valid_lf, enc_lf);
      end
    end
    tests_run++;
    if ({pend_hf[3], pend_lf[3]} !== 2'b11) begin
      failures++;
      $display("FAIL stall_pending3: got %b/%b, expected 1/1", pend_hf[3], pend_lf[3]);
    end
    push_both(2'd3, 1'b0);
    wait_drain("stall", 10);
  endtask

  task automatic test_overflow();
    rdy  = 1'b0;
    data = 4'b0100;
    tick();
    data = '0;
    push_both(2'd2, 1'b0);
    tick();
    data = 4'b0010;
    tick();
    data = '0;
    tests_run++;
    if ({ovf_hf, ovf_lf} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_first_edge: got %b/%b, expected 0/0", ovf_hf, ovf_lf);
    end
    tick();
    data = 4'b0010;
    tick();
    data = '0;
    tests_run++;
    if ({ovf_hf, ovf_lf} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_set: got %b/%b, expected 1/1", ovf_hf, ovf_lf);
    end
    tick();
    tick();
    tests_run++;
    if ({ovf_hf, ovf_lf} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_sticky: got %b/%b, expected 1/1", ovf_hf, ovf_lf);
    end
    data    = 4'b0010;
    clr_ovf = 1'b1;
    tick();
    data = '0;
    tests_run++;
    if ({ovf_hf, ovf_lf} !== 2'b11) begin
      failures++;
      $display("FAIL ovf_set_wins: got %b/%b, expected 1/1", ovf_hf, ovf_lf);
    end
    tick();
    clr_ovf = 1'b0;
    tests_run++;
    if ({ovf_hf, ovf_lf} !== 2'b00) begin
      failures++;
      $display("FAIL ovf_clear: got %b/%b, expected 0/0", ovf_hf, ovf_lf);
    end
    push_both(2'd1, 1'b0);
    wait_drain("ovf", 10);
  endtask

  task automatic test_reset_mid();
    rdy  = 1'b0;
    data = 4'b0100;
    tick();
    data = '0;
    push_both(2'd2, 1'b0);
    tick();
    data = 4'b1010;
    tick();
    data = '0;
    tests_run++;
    if ({valid_hf, pend_hf, valid_lf, pend_lf} !== {1'b1, 4'b1010, 1'b1, 4'b1010}) begin
      failures++;
      $display("FAIL rmid_setup: got v%b p%b / v%b p%b, expected v1 p1010",
               valid_hf, pend_hf, valid_lf, pend_lf);
    end
    rst  = 1'b1;
    data = 4'b0100;
    tick();
    q_hf.delete();
    q_lf.delete();
    tests_run++;
    if ({valid_hf, enc_hf, mult_hf, ovf_hf, pend_hf, valid_lf, enc_lf, mult_lf, ovf_lf, pend_lf} !== 18'd0) begin
      failures++;
      $display("FAIL rmid_reset: got v%b e%0d m%b p%b / v%b e%0d m%b p%b, expected all 0",
               valid_hf, enc_hf, mult_hf, pend_hf, valid_lf, enc_lf, mult_lf, pend_lf);
    end
    rst = 1'b0;
    tick();
    push_both(2'd2, 1'b0);
    tests_run++;
    if ({pend_hf, pend_lf} !== {4'b0100, 4'b0100}) begin
      failures++;
      $display("FAIL rmid_release_event: got %b/%b, expected 0100/0100", pend_hf, pend_lf);
    end
    wait_drain("rmid", 10);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if ({valid_hf, valid_lf, pend_hf, pend_lf} !== 10'd0) begin
        failures++;
        $display("FAIL rmid_single_event_%0d: got v%b%b p%b/%b, expected idle and empty",
                 i, valid_hf, valid_lf, pend_hf, pend_lf);
      end
    end
    rdy  = 1'b0;
    data = '0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
